sequenciador_display: RTL and testbench

Controller that sequences the coffee machine's selection-message 7-segment decoders (S1/S2/S3). It generates the 2-bit character index (saida1Contador = MSB, saida2Contador = LSB) that steps each decoder through its four characters. It also one-hot enables the decoder for the current selection and blanks the display. It sits between the selection/brewing control logic and the per-selection decoders.

---
 rtl/sequenciador_display_if.sv | 22 ++
 rtl/sequenciador_display.sv | 156 +++++++++++++++
 tb/tb_sequenciador_display.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sequenciador_display_if.sv
// Bundle of selection/control inputs and decoder-drive outputs for the
// coffee machine selection-message display sequencer.
interface sequenciador_display_if;
    logic [1:0] selecao;
    logic       confirma;
    logic       liberar;
    logic       saida1Contador;
    logic       saida2Contador;
    logic [2:0] sel_decoder;
    logic       apagado;
    logic       ocupado;

    modport master (
        output selecao, confirma, liberar,
        input  saida1Contador, saida2Contador, sel_decoder, apagado, ocupado
    );

    modport slave (
        input  selecao, confirma, liberar,
        output saida1Contador, saida2Contador, sel_decoder, apagado, ocupado
    );
endinterface

// File: rtl/sequenciador_display.sv
// Steps the S1/S2/S3 selection-message decoders through their four characters,
// enabling the active decoder and blanking the display while idle or switching.
module sequenciador_display #(
    parameter int DIV_WIDTH  = 4,
    parameter int HOLD_TICKS = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    sequenciador_display_if.slave bus
);

    typedef enum logic [1:0] {
        OCIOSO,
        EXIBE,
        TROCA,
        TRAVADO
    } state_t;

    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

    state_t               state, next_state;
    logic [DIV_WIDTH-1:0] presc, next_presc;
    logic [HW-1:0]        hold_cnt, next_hold;
    logic [1:0]           idx, next_idx;
    logic [1:0]           sel_reg, next_sel;
    logic [2:0]           sel_dec_q, next_sel_dec;
    logic                 apagado_q, next_apagado;
    logic                 ocupado_q, next_ocupado;
    logic                 tick;

    function automatic logic [2:0] onehot(input logic [1:0] s);
        case (s)
            2'b01:   onehot = 3'b001;
            2'b10:   onehot = 3'b010;
            2'b11:   onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
    endfunction

    assign tick = &presc;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= OCIOSO;
            presc     <= '0;
            hold_cnt  <= '0;
            idx       <= 2'b00;
            sel_reg   <= 2'b00;
            sel_dec_q <= 3'b000;
            apagado_q <= 1'b1;
            ocupado_q <= 1'b0;
        end else begin
            state     <= next_state;
            presc     <= next_presc;
            hold_cnt  <= next_hold;
            idx       <= next_idx;
            sel_reg   <= next_sel;
            sel_dec_q <= next_sel_dec;
            apagado_q <= next_apagado;
            ocupado_q <= next_ocupado;
        end
    end

    // Any transition clears the prescaler so each state starts a full tick period.
    always_comb begin
        next_state = state;
        next_presc = presc + DIV_WIDTH'(1);
        next_hold  = hold_cnt;
        next_idx   = idx;
        next_sel   = sel_reg;

        case (state)
            OCIOSO: begin
                next_idx = 2'b00;
                if (bus.selecao != 2'b00) begin
                    next_sel   = bus.selecao;
                    next_hold  = '0;
                    next_state = EXIBE;
                    next_presc = '0;
                end
            end
            EXIBE: begin
                if (tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        next_idx  = idx + 2'd1;
                        next_hold = '0;
                    end else begin
                        next_hold = hold_cnt + HW'(1);
                    end
                end
                if (bus.selecao == 2'b00) begin
                    next_state = OCIOSO;
                    next_presc = '0;
                    next_hold  = '0;
                    next_idx   = 2'b00;
                end else if (bus.selecao != sel_reg) begin
                    next_state = TROCA;
                    next_sel   = bus.selecao;
                    next_presc = '0;
                    next_hold  = '0;
                    next_idx   = 2'b00;
                end else if (bus.confirma) begin
                    next_state = TRAVADO;
                    next_presc = '0;
                    next_idx   = 2'b11;
                end
            end
            TROCA: begin
                next_idx = 2'b00;
                if (bus.selecao == 2'b00) begin
                    next_state = OCIOSO;
                    next_presc = '0;
                end else begin
                    next_sel = bus.selecao;
                    if (tick) begin
                        next_state = EXIBE;
                        next_presc = '0;
                        next_hold  = '0;
                    end
                end
            end
            TRAVADO: begin
                next_idx = 2'b11;
                if (bus.liberar) begin
                    next_state = OCIOSO;
                    next_presc = '0;
                    next_idx   = 2'b00;
                end
            end
            default: begin
                next_state = OCIOSO;
                next_presc = '0;
                next_hold  = '0;
                next_idx   = 2'b00;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they track state without lag.
    always_comb begin
        next_apagado = (next_state == OCIOSO) || (next_state == TROCA);
        next_ocupado = (next_state == TRAVADO);
        next_sel_dec = 3'b000;
        if ((next_state == EXIBE) || (next_state == TRAVADO)) begin
            next_sel_dec = onehot(next_sel);
        end
    end

    assign bus.saida1Contador = idx[1];
    assign bus.saida2Contador = idx[0];
    assign bus.sel_decoder    = sel_dec_q;
    assign bus.apagado        = apagado_q;
    assign bus.ocupado        = ocupado_q;

endmodule

// File: tb/tb_sequenciador_display.sv
// Directed bench for sequenciador_display with DIV_WIDTH=2, HOLD_TICKS=2
// (tick every 4 clocks, character change every 8 clocks).
module tb_sequenciador_display;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   testCount = 0;
    int   failCount = 0;

    sequenciador_display_if bus ();

    sequenciador_display #(
        .DIV_WIDTH (2),
        .HOLD_TICKS(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic applyStimulus(input logic [1:0] sel, input logic conf, input logic lib);
        bus.selecao  = sel;
        bus.confirma = conf;
        bus.liberar  = lib;
    endtask

    // Packed as {apagado, sel_decoder, index, ocupado}.
    task automatic checkOutput(input string tag, input logic ap, input logic [2:0] sd,
                               input logic [1:0] ix, input logic oc);
        logic [6:0] obs;
        logic [6:0] exp;
        obs = {bus.apagado, bus.sel_decoder, bus.saida1Contador, bus.saida2Contador, bus.ocupado};
        exp = {ap, sd, ix, oc};
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed ap=%b sel=%b idx=%b oc=%b, expected ap=%b sel=%b idx=%b oc=%b",
                   tag, obs[6], obs[5:3], obs[2:1], obs[0], exp[6], exp[5:3], exp[2:1], exp[0]);
        end
    endtask

    initial begin
        applyStimulus(2'b00, 1'b0, 1'b0);

        reset = 1'b1;
        step(3);
        checkOutput("reset", 1'b1, 3'b000, 2'b00, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            checkOutput("idle_hold", 1'b1, 3'b000, 2'b00, 1'b0);
        end

        applyStimulus(2'b10, 1'b0, 1'b0);
        step(1);
        checkOutput("s2_enter", 1'b0, 3'b010, 2'b00, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step(7);
            checkOutput("s2_hold", 1'b0, 3'b010, 2'(k - 1), 1'b0);
            step(1);
            checkOutput("s2_step", 1'b0, 3'b010, 2'(k), 1'b0);
        end

        step(16);
        checkOutput("s2_idx10", 1'b0, 3'b010, 2'b10, 1'b0);
        applyStimulus(2'b01, 1'b0, 1'b0);
        step(1);
        checkOutput("troca_blank", 1'b1, 3'b000, 2'b00, 1'b0);
        step(3);
        checkOutput("troca_wait", 1'b1, 3'b000, 2'b00, 1'b0);
        step(1);
        checkOutput("s1_enter", 1'b0, 3'b001, 2'b00, 1'b0);

        applyStimulus(2'b11, 1'b0, 1'b0);
        step(1);
        checkOutput("troca_s3", 1'b1, 3'b000, 2'b00, 1'b0);
        step(4);
        checkOutput("s3_enter", 1'b0, 3'b100, 2'b00, 1'b0);
        applyStimulus(2'b11, 1'b1, 1'b0);
        step(1);
        applyStimulus(2'b11, 1'b0, 1'b0);
        checkOutput("travado", 1'b0, 3'b100, 2'b11, 1'b1);
        applyStimulus(2'b01, 1'b1, 1'b0);
        step(1);
        applyStimulus(2'b01, 1'b0, 1'b0);
        checkOutput("travado_ignore", 1'b0, 3'b100, 2'b11, 1'b1);
        step(10);
        checkOutput("travado_stable", 1'b0, 3'b100, 2'b11, 1'b1);
        applyStimulus(2'b00, 1'b0, 1'b1);
        step(1);
        applyStimulus(2'b00, 1'b0, 1'b0);
        checkOutput("liberar", 1'b1, 3'b000, 2'b00, 1'b0);

        applyStimulus(2'b01, 1'b0, 1'b0);
        step(1);
        checkOutput("s1_enter2", 1'b0, 3'b001, 2'b00, 1'b0);
        applyStimulus(2'b10, 1'b1, 1'b0);
        step(1);
        applyStimulus(2'b10, 1'b0, 1'b0);
        checkOutput("change_beats_conf", 1'b1, 3'b000, 2'b00, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b0);
        step(1);
        checkOutput("troca_to_idle", 1'b1, 3'b000, 2'b00, 1'b0);
        step(6);
        checkOutput("idle_after_troca", 1'b1, 3'b000, 2'b00, 1'b0);

        applyStimulus(2'b01, 1'b0, 1'b0);
        step(1);
        checkOutput("s1_enter3", 1'b0, 3'b001, 2'b00, 1'b0);
        applyStimulus(2'b10, 1'b0, 1'b0);
        step(2);
        applyStimulus(2'b11, 1'b0, 1'b0);
        step(1);
        checkOutput("troca_rechange", 1'b1, 3'b000, 2'b00, 1'b0);
        step(1);
        checkOutput("troca_last", 1'b1, 3'b000, 2'b00, 1'b0);
        step(1);
        checkOutput("troca_no_restart", 1'b0, 3'b100, 2'b00, 1'b0);

        applyStimulus(2'b11, 1'b1, 1'b0);
        step(1);
        applyStimulus(2'b11, 1'b0, 1'b0);
        checkOutput("travado2", 1'b0, 3'b100, 2'b11, 1'b1);
        applyStimulus(2'b00, 1'b0, 1'b0);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checkOutput("reset_travado", 1'b1, 3'b000, 2'b00, 1'b0);

        applyStimulus(2'b10, 1'b0, 1'b0);
        step(1);
        checkOutput("s2_enter2", 1'b0, 3'b010, 2'b00, 1'b0);
        step(5);
        checkOutput("s2_midhold", 1'b0, 3'b010, 2'b00, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b0);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checkOutput("reset_exibe", 1'b1, 3'b000, 2'b00, 1'b0);

        applyStimulus(2'b00, 1'b0, 1'b1);
        step(1);
        applyStimulus(2'b00, 1'b0, 1'b0);
        checkOutput("idle_liberar", 1'b1, 3'b000, 2'b00, 1'b0);
        applyStimulus(2'b00, 1'b1, 1'b0);
        step(1);
        applyStimulus(2'b00, 1'b0, 1'b0);
        checkOutput("idle_confirma", 1'b1, 3'b000, 2'b00, 1'b0);
        step(2);
        checkOutput("idle_final", 1'b1, 3'b000, 2'b00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
